// File: rtl/local_inject_ni.sv
// Local-port injection interface for the minBD router: queues core flits and
// offers the head flit to the router once per attempt until it is granted.
`ifndef WIDTH_FLIT_EXT
`define WIDTH_FLIT_EXT 40
`endif
`ifndef FLIT_VLD_BIT
`define FLIT_VLD_BIT (`WIDTH_FLIT_EXT-1)
`endif
`ifndef FLIT_GOLDEN_BIT
`define FLIT_GOLDEN_BIT (`WIDTH_FLIT_EXT-2)
`endif

module local_inject_ni #(
    parameter int DEPTH     = 4,
    parameter int GNT_LAT   = 2,
    parameter int STARVE_TH = 8,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic [`WIDTH_FLIT_EXT-1:0]     core_flit,
    input  logic                           core_valid,
    output logic                           core_ready,
    output logic [`WIDTH_FLIT_EXT-1:0]     din_l,
    input  logic                           local_inject_gnt,
    output logic                           starve,
    output logic [$clog2(STARVE_TH+1)-1:0] retry_cnt,
    output logic [CNT_W-1:0]               inj_count,
    output logic [$clog2(DEPTH+1)-1:0]     fifo_level
);

    localparam int FW = `WIDTH_FLIT_EXT;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int RW = $clog2(STARVE_TH+1);
    localparam int WW = $clog2(GNT_LAT+1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t         state, state_nxt;
    logic [FW-1:0]  mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [LW-1:0]  count;
    logic [WW-1:0]  wait_cnt;
    logic [FW-1:0]  din_nxt;
    logic           push, pop, fail, sample;

    // Ready is withheld during reset and judged on the registered count only,
    // so a full FIFO never accepts even when the head pops this cycle.
    assign core_ready = !n_rst && (count < LW'(DEPTH));
    assign push       = core_valid && core_ready;
    assign sample     = (state == WAIT) && (wait_cnt == WW'(GNT_LAT));
    assign pop        = sample && local_inject_gnt;
    assign fail       = sample && !local_inject_gnt;
    assign fifo_level = count;

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_nxt = state;
        din_nxt   = '0;
        case (state)
            IDLE:    if (count != '0) state_nxt = SEND;
            SEND:    state_nxt = WAIT;
            WAIT: begin
                if (pop)       state_nxt = IDLE;
                else if (fail) state_nxt = SEND;
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == SEND) begin
            din_nxt                   = mem[rd_ptr];
            din_nxt[`FLIT_VLD_BIT]    = 1'b1;
            din_nxt[`FLIT_GOLDEN_BIT] = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wait_cnt  <= '0;
            din_l     <= '0;
            retry_cnt <= '0;
            starve    <= 1'b0;
            inj_count <= '0;
        end else begin
            state    <= state_nxt;
            din_l    <= din_nxt;
            wait_cnt <= (state == WAIT) ? wait_cnt + WW'(1) : WW'(1);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + LW'(push) - LW'(pop);
            if (pop) begin
                retry_cnt <= '0;
                inj_count <= inj_count + CNT_W'(1);
            end else if (fail && (retry_cnt != RW'(STARVE_TH))) begin
                retry_cnt <= retry_cnt + RW'(1);
            end
            // One cycle behind retry_cnt reaching the threshold.
            starve <= !pop && (retry_cnt == RW'(STARVE_TH));
        end
    end

    // NOTE: flit storage is not reset; the count and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= core_flit;
    end

endmodule
